// File: rtl/mmio_init_pkg.sv
// Shared types and widths for the MMIO host initiator.
package mmio_init_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_t;

  // Saturating event-counter increment.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + STAT_W'(1) : v;
  endfunction

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Read-response timeout counter: zero in the strobe cycle, expired at TIMEOUT_CYCLES-1.
module mmio_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             running;

  assign expired = running && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      running <= 1'b1;
    end else if (running && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmio_host_initiator.sv
// Single-outstanding MMIO initiator: command -> strobe -> (read response | timeout) -> completion.
// Optional statistics counters are built only when MMIO_INIT_STATS_EN is defined.
module mmio_host_initiator
  import mmio_init_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TID_W          = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mmio_wr_valid,
  output logic              mmio_rd_valid,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wdata,
  output logic [TID_W-1:0]  mmio_tid,
  input  logic              mmio_rsp_valid,
  input  logic [TID_W-1:0]  mmio_rsp_tid,
  input  logic [DATA_W-1:0] mmio_rsp_data,
  output logic [STAT_W-1:0] stat_reads,
  output logic [STAT_W-1:0] stat_writes,
  output logic [STAT_W-1:0] stat_timeouts,
  output logic [STAT_W-1:0] stat_spurious
);

  state_t              state_q, state_d;
  logic                is_write_q, is_write_d;
  logic [TID_W-1:0]    tid_cnt_q, tid_cnt_d;
  logic                wr_d, rd_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d, rdata_d;
  logic [TID_W-1:0]    tid_d;
  logic                tmr_start, tmr_clear, tmr_expired;
  logic                rsp_match_c;

  assign rsp_match_c = mmio_rsp_valid && (mmio_rsp_tid == mmio_tid);

  mmio_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .start   (tmr_start),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  // Next-state and next-output logic; a matching response beats timeout expiry.
  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    tid_cnt_d   = tid_cnt_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    addr_d      = mmio_addr;
    wdata_d     = mmio_wdata;
    tid_d       = mmio_tid;
    rsp_valid_d = rsp_valid;
    rdata_d     = rsp_rdata;
    rsp_err_d   = rsp_err;
    tmr_start   = 1'b0;
    tmr_clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = ISSUE;
          is_write_d = cmd_write;
          wr_d       = cmd_write;
          rd_d       = !cmd_write;
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          tid_d      = tid_cnt_q;
          tid_cnt_d  = tid_cnt_q + TID_W'(1);
          tmr_start  = !cmd_write;
        end
      end
      ISSUE: begin
        if (is_write_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_match_c) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = mmio_rsp_data;
          rsp_err_d   = 1'b0;
          tmr_clear   = 1'b1;
        end else if (tmr_expired) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          rsp_err_d   = 1'b1;
          tmr_clear   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready     <= 1'b1;
      is_write_q    <= 1'b0;
      tid_cnt_q     <= '0;
      mmio_wr_valid <= 1'b0;
      mmio_rd_valid <= 1'b0;
      mmio_addr     <= '0;
      mmio_wdata    <= '0;
      mmio_tid      <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready     <= (state_d == IDLE);
      is_write_q    <= is_write_d;
      tid_cnt_q     <= tid_cnt_d;
      mmio_wr_valid <= wr_d;
      mmio_rd_valid <= rd_d;
      mmio_addr     <= addr_d;
      mmio_wdata    <= wdata_d;
      mmio_tid      <= tid_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rdata_d;
      rsp_err       <= rsp_err_d;
    end
  end

`ifdef MMIO_INIT_STATS_EN
  logic spurious_c, timeout_c;

  assign spurious_c = mmio_rsp_valid && !((state_q == WAIT_RSP) && rsp_match_c);
  assign timeout_c  = (state_q == WAIT_RSP) && tmr_expired && !rsp_match_c;

  // Issue counts follow the strobes; all counters saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reads    <= '0;
      stat_writes   <= '0;
      stat_timeouts <= '0;
      stat_spurious <= '0;
    end else begin
      stat_reads    <= sat_inc(stat_reads, mmio_rd_valid);
      stat_writes   <= sat_inc(stat_writes, mmio_wr_valid);
      stat_timeouts <= sat_inc(stat_timeouts, timeout_c);
      stat_spurious <= sat_inc(stat_spurious, spurious_c);
    end
  end
`else
  assign stat_reads    = '0;
  assign stat_writes   = '0;
  assign stat_timeouts = '0;
  assign stat_spurious = '0;
`endif

endmodule

// File: tb/tb_mmio_host_initiator.sv
// Bench for mmio_host_initiator: directed scenarios plus randomized traffic vs a cycle-timing model.
module tb_mmio_host_initiator;
  import mmio_init_pkg::*;

  localparam int unsigned TO    = 8;
  localparam int unsigned TID_W = 9;
`ifdef MMIO_INIT_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic              clk, rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mmio_wr_valid, mmio_rd_valid;
  logic [ADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0] mmio_wdata;
  logic [TID_W-1:0]  mmio_tid;
  logic              mmio_rsp_valid;
  logic [TID_W-1:0]  mmio_rsp_tid;
  logic [DATA_W-1:0] mmio_rsp_data;
  logic [31:0]       stat_reads, stat_writes, stat_timeouts, stat_spurious;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;
  int unsigned m_tid, m_reads, m_writes, m_tos, m_spur;

  mmio_host_initiator #(.TIMEOUT_CYCLES(TO), .TID_W(TID_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_tid(mmio_tid),
    .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_tid(mmio_rsp_tid), .mmio_rsp_data(mmio_rsp_data),
    .stat_reads(stat_reads), .stat_writes(stat_writes),
    .stat_timeouts(stat_timeouts), .stat_spurious(stat_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tid = 0; m_reads = 0; m_writes = 0; m_tos = 0; m_spur = 0;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, ".reads"},    64'(stat_reads),    STATS_EN ? 64'(m_reads)  : 64'd0);
    chk({tag, ".writes"},   64'(stat_writes),   STATS_EN ? 64'(m_writes) : 64'd0);
    chk({tag, ".timeouts"}, 64'(stat_timeouts), STATS_EN ? 64'(m_tos)    : 64'd0);
    chk({tag, ".spurious"}, 64'(stat_spurious), STATS_EN ? 64'(m_spur)   : 64'd0);
  endtask

  // Called on the negedge of the first rsp_valid cycle; holds off rsp_ready for bp cycles.
  task automatic finish_rsp(input int bp, input logic [63:0] exp_data, input logic exp_err);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp.rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp.rsp_rdata", rsp_rdata, exp_data);
      chk("bp.rsp_err", 64'(rsp_err), 64'(exp_err));
      chk("bp.cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("done.cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic handshake(input logic wr, input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    chk("idle.cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [63:0] d, input int bp);
    logic [TID_W-1:0] et;
    et = TID_W'(m_tid);
    handshake(1'b1, a, d);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 16'($urandom); cmd_wdata = {$urandom, $urandom};
    chk("wr.strobe", 64'(mmio_wr_valid), 64'd1);
    chk("wr.rd_strobe", 64'(mmio_rd_valid), 64'd0);
    chk("wr.addr", 64'(mmio_addr), 64'(a));
    chk("wr.wdata", mmio_wdata, d);
    chk("wr.tid", 64'(mmio_tid), 64'(et));
    chk("wr.early_rsp", 64'(rsp_valid), 64'd0);
    m_tid = (m_tid + 1) % (1 << TID_W);
    m_writes++;
    @(negedge clk);
    chk("wr.strobe_off", 64'(mmio_wr_valid), 64'd0);
    chk("wr.addr_hold", 64'(mmio_addr), 64'(a));
    chk("wr.rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr.rsp_err", 64'(rsp_err), 64'd0);
    chk("wr.rsp_rdata", rsp_rdata, 64'd0);
    finish_rsp(bp, 64'd0, 1'b0);
  endtask

  // d: cycle (1 = strobe cycle) of the response pulse, 0 = none, >TO = late after completion.
  // good: response carries the issued tid. wd: cycle of an extra wrong-tid pulse, 0 = none.
  task automatic do_read(input logic [15:0] a, input logic [63:0] data, input int d,
                         input bit good, input int wd, input int bp);
    logic [TID_W-1:0] et;
    bit match;
    int exp_k;
    et    = TID_W'(m_tid);
    match = good && (d >= 2) && (d <= int'(TO));
    exp_k = match ? d + 1 : int'(TO) + 1;
    handshake(1'b0, a, {$urandom, $urandom});
    m_tid = (m_tid + 1) % (1 << TID_W);
    m_reads++;
    for (int k = 1; k <= exp_k; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      mmio_rsp_valid = 1'b0;
      chk("rd.rsp_valid_timing", 64'(rsp_valid), 64'(k == exp_k));
      chk("rd.cmd_ready_busy", 64'(cmd_ready), 64'd0);
      if (k == 1) begin
        chk("rd.strobe", 64'(mmio_rd_valid), 64'd1);
        chk("rd.wr_strobe", 64'(mmio_wr_valid), 64'd0);
        chk("rd.addr", 64'(mmio_addr), 64'(a));
        chk("rd.tid", 64'(mmio_tid), 64'(et));
      end else begin
        chk("rd.strobe_off", 64'(mmio_rd_valid), 64'd0);
      end
      if (k < exp_k && d != 0 && k == d) begin
        mmio_rsp_valid = 1'b1;
        mmio_rsp_tid   = good ? et : et ^ TID_W'(1);
        mmio_rsp_data  = data;
        if (!match) m_spur++;
      end else if (k < exp_k && wd != 0 && k == wd) begin
        mmio_rsp_valid = 1'b1;
        mmio_rsp_tid   = et ^ TID_W'(2);
        mmio_rsp_data  = ~data;
        m_spur++;
      end
    end
    chk("rd.rsp_rdata", rsp_rdata, match ? data : 64'd0);
    chk("rd.rsp_err", 64'(rsp_err), 64'(!match));
    if (!match) m_tos++;
    finish_rsp(bp, match ? data : 64'd0, !match);
    if (d > int'(TO)) begin
      mmio_rsp_valid = 1'b1;
      mmio_rsp_tid   = good ? et : et ^ TID_W'(1);
      mmio_rsp_data  = data;
      m_spur++;
      @(negedge clk);
      mmio_rsp_valid = 1'b0;
      chk("late.ignored", 64'(rsp_valid), 64'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, 64'd0);
    chk({tag, ".rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, ".wr_strobe"}, 64'(mmio_wr_valid), 64'd0);
    chk({tag, ".rd_strobe"}, 64'(mmio_rd_valid), 64'd0);
    chk({tag, ".addr"}, 64'(mmio_addr), 64'd0);
    chk({tag, ".wdata"}, mmio_wdata, 64'd0);
    chk({tag, ".tid"}, 64'(mmio_tid), 64'd0);
    chk({tag, ".stat_sum"},
        64'(stat_reads) + 64'(stat_writes) + 64'(stat_timeouts) + 64'(stat_spurious), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; mmio_rsp_valid = 1'b0; mmio_rsp_tid = '0; mmio_rsp_data = '0;
    model_reset();
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.cmd_ready", 64'(cmd_ready), 64'd1);

    // Posted write, then a read answered with tid 1.
    do_write(16'h0300, 64'hDEAD_BEEF, 0);
    do_read(16'h0002, 64'h1234, 6, 1'b1, 0, 0);
    chk_stats("after_read");

    // Timeout with a late response carrying the old tid.
    do_read(16'h0010, 64'hCAFE, 20, 1'b1, 0, 0);
    chk_stats("after_timeout");

    // Response lands exactly in the expiry cycle.
    do_read(16'h0011, 64'h5555_AAAA_0F0F_F0F0, int'(TO), 1'b1, 0, 1);
    // Wrong-tid pulse before the matching one.
    do_read(16'h0012, 64'h0BAD_F00D, 5, 1'b1, 3, 0);
    // Response in the strobe cycle is spurious and the read times out.
    do_read(16'h0013, 64'h77, 1, 1'b1, 0, 0);
    // Ten cycles of backpressure on a read and on a write.
    do_read(16'h0014, 64'hFEED_FACE_1234_5678, 4, 1'b1, 2, 10);
    do_write(16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 10);
    chk_stats("directed");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_write(16'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)));
      else
        do_read(16'($urandom), {$urandom, $urandom}, int'($urandom_range(0, TO + 3)),
                $urandom_range(0, 3) != 0, int'($urandom_range(0, TO)),
                int'($urandom_range(0, 3)));
    end
    chk_stats("random");

    // Reset while waiting for a read response.
    handshake(1'b0, 16'h0042, 64'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_reset.cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (TO + 2) @(negedge clk);
    chk("mid_reset.no_rsp", 64'(rsp_valid), 64'd0);
    chk_stats("post_reset");

    // 2^TID_W + 2 writes: tid runs 0..511, then 0, then 1.
    for (int i = 0; i < (1 << TID_W) + 2; i++)
      do_write(16'(i), 64'(i) * 64'h0101, 0);
    chk("wrap.last_tid", 64'(mmio_tid), 64'd1);
    chk_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
